pcs_serdes_word_align_ctrl: RTL and testbench
=============================================

// Module: pcs_serdes_word_align_ctrl
// PURPOSE
//  Word-alignment controller for the Xilinx SERDES RX parallel bus (sig_data, 320b = 32 x 10b symbols).
//  Scans each RX word for K28.5 commas and classifies each match as symbol-aligned or bit-misaligned.
//  Drives one-cycle bitslip pulses to the SERDES until the comma is symbol-aligned.
//  Declares/removes word_lock for the downstream PCS 8b/10b decoder.
// PARAMETERS
//  DATA_W     320           RX parallel word width; multiple of SYM_W
//  SYM_W      10            symbol width
//  COMMA      10'b0011111010 K28.5 RD- pattern; bitwise inverse also matches (RD+)
//  SLIP_WAIT  32            cycles to ignore data after a bitslip pulse (SERDES settle)
//  LOCK_CNT   4             consecutive aligned-comma words needed to lock
//  UNLOCK_CNT 8             misaligned-comma words in LOCKED (no aligned word between) to drop lock
// PORTS
//  clk          in   1       RX parallel clock
//  reset        in   1       async reset, active-low
//  enable       in   1       0: force HUNT, no slips, lock=0
//  rx_valid     in   1       sig_data qualifier
//  sig_data     in   DATA_W  RX parallel word from SERDES
//  bitslip      out  1       one-cycle slip request to SERDES
//  word_lock    out  1       alignment locked
//  align_state  out  3       FSM state code: HUNT=0 SLIP=1 WAIT=2 VERIFY=3 LOCKED=4
//  slip_count   out  8       total bitslip pulses since reset, saturates at 255
//  lock_loss    out  1       one-cycle pulse on LOCKED->HUNT exit
// BEHAVIOUR
//  Reset (reset=0): state=HUNT; bitslip=0; word_lock=0; slip_count=0; lock_loss=0; all counters 0.
//  Detection (combinational, valid word only):
//   - aligned_hit  = any k in 0..DATA_W/SYM_W-1 with sig_data[k*SYM_W +: SYM_W] == COMMA or ~COMMA.
//   - misalign_hit = any bit offset o not a multiple of SYM_W, o <= DATA_W-SYM_W, whose window matches.
//   - Both set in one word: treat as aligned_hit only.
//   - rx_valid=0: no hit of either kind; counters and state hold, except the WAIT timer.
//  FSM (registered; all outputs registered, 1-cycle latency from the sampled word):
//   - HUNT:   aligned_hit -> VERIFY with good_cnt=1; misalign_hit -> SLIP; else stay.
//   - SLIP:   bitslip=1 for exactly this cycle; slip_count+=1 (saturating); -> WAIT with wait_cnt=0.
//   - WAIT:   wait_cnt increments every clk, independent of rx_valid; data ignored;
//             wait_cnt==SLIP_WAIT-1 -> HUNT.
//   - VERIFY: aligned_hit -> good_cnt+=1, LOCKED when good_cnt reaches LOCK_CNT;
//             misalign_hit -> HUNT, good_cnt=0; valid word with no comma -> stay, good_cnt kept.
//   - LOCKED: word_lock=1; misalign_hit -> bad_cnt+=1; aligned_hit -> bad_cnt=0;
//             bad_cnt reaches UNLOCK_CNT -> HUNT; lock_loss=1 and word_lock=0 in the next cycle.
//  word_lock goes high in the cycle after the LOCK_CNT-th aligned word is sampled.
//  Back-to-back slips are at least SLIP_WAIT+2 cycles apart.
//  enable=0 (synchronous): next state HUNT, counters cleared; slip_count kept.
//   - A bitslip already issued completes as a single pulse. No lock_loss pulse is generated.
//  Async reset mid-WAIT or mid-LOCKED: immediate return to reset values; no lock_loss pulse.
// TESTING
//  1. Aligned K28.5 in symbol 0, 4 valid words -> word_lock=1 in the cycle after word 4; bitslip never asserted.
//  2. Comma at bit offset 3 -> bitslip pulse 1 cycle; data ignored 32 cycles; after the model slips, aligned -> lock; slip_count=1.
//  3. LOCKED; 8 misaligned-comma words -> lock_loss pulse and word_lock=0; with an aligned word at #7, lock is held.
//  4. RD+ comma (~COMMA) at symbol 31 -> treated as aligned; lock after 4 words; rx_valid=0 gaps do not reset good_cnt.
//  5. Misalignment held for 300 slips -> slip_count saturates at 255; pulses stay >= 34 cycles apart.
//  6. enable=0 in VERIFY, and reset=0 in LOCKED -> state=HUNT, word_lock=0, no spurious bitslip/lock_loss.

Source files
------------

// File: rtl/pcs_serdes_word_align_ctrl_if.sv
// ---------------------------------------------------------------------------
// pcs_serdes_word_align_ctrl_if
//   SERDES RX parallel bus as seen by the word-alignment controller.
//
//   rx_valid  qualifier for sig_data
//   sig_data  RX parallel word (DATA_W bits, SYM_W-bit symbols, symbol 0 in LSBs)
//   bitslip   one-cycle slip request back to the SERDES
//
//   master : SERDES side (drives the data, receives bitslip)
//   slave  : alignment controller (receives the data, drives bitslip)
// ---------------------------------------------------------------------------
interface pcs_serdes_word_align_ctrl_if #(
    parameter int DATA_W = 320
) ();
    logic              rx_valid;
    logic [DATA_W-1:0] sig_data;
    logic              bitslip;

    modport master (
        output rx_valid,
        output sig_data,
        input  bitslip
    );

    modport slave (
        input  rx_valid,
        input  sig_data,
        output bitslip
    );
endinterface : pcs_serdes_word_align_ctrl_if

// File: rtl/pcs_serdes_word_align_ctrl.sv
// ---------------------------------------------------------------------------
// pcs_serdes_word_align_ctrl
//   Word-alignment controller for a SERDES RX parallel bus. Every valid word
//   is scanned for K28.5 commas (either running disparity). A comma on a
//   symbol boundary counts as aligned; a comma at any other bit offset counts
//   as misaligned and triggers a bitslip pulse, after which data is ignored
//   while the SERDES settles. LOCK_CNT aligned words declare word_lock;
//   UNLOCK_CNT misaligned words with no aligned word in between drop it.
//
// Ports
//   clk          RX parallel clock
//   reset        asynchronous reset, active-low
//   enable       0 forces HUNT, clears counters, suppresses slips and lock
//   rx           SERDES bus (rx_valid, sig_data in; bitslip out)
//   word_lock    alignment locked
//   align_state  HUNT=0 SLIP=1 WAIT=2 VERIFY=3 LOCKED=4
//   slip_count   bitslip pulses since reset, saturating at 255
//   lock_loss    one-cycle pulse when lock is lost through misalignment
//
//   All outputs are registered: they reflect the word sampled on the
//   previous rising edge.
// ---------------------------------------------------------------------------
module pcs_serdes_word_align_ctrl #(
    parameter int               DATA_W     = 320,
    parameter int               SYM_W      = 10,
    parameter logic [SYM_W-1:0] COMMA      = 10'b0011111010,
    parameter int               SLIP_WAIT  = 32,
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    pcs_serdes_word_align_ctrl_if.slave   rx,
    output logic                          word_lock,
    output logic [2:0]                    align_state,
    output logic [7:0]                    slip_count,
    output logic                          lock_loss
);

    // -----------------------------------------------------------------------
    // Local types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_SLIP   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // Number of bit offsets at which a full symbol window fits in the word.
    localparam int N_OFF  = DATA_W - SYM_W + 1;

    localparam int WAIT_W = (SLIP_WAIT  > 1) ? $clog2(SLIP_WAIT)  : 1;
    localparam int GOOD_W = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT)   : 1;
    localparam int BAD_W  = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT) : 1;

    // Terminal counter values; the counters never need to hold the full count
    // because the transition fires on the word that would reach it.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

    // -----------------------------------------------------------------------
    // Comma detection
    // -----------------------------------------------------------------------
    logic [N_OFF-1:0] win_hit;
    logic             any_aligned;
    logic             any_misalign;
    logic             aligned_hit;
    logic             misalign_hit;

    genvar g_off;
    generate
        for (g_off = 0; g_off < N_OFF; g_off++) begin : g_win
            assign win_hit[g_off] = (rx.sig_data[g_off +: SYM_W] == COMMA) ||
                                    (rx.sig_data[g_off +: SYM_W] == ~COMMA);
        end
    endgenerate

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        any_aligned  = 1'b0;
        any_misalign = 1'b0;
        for (int i = 0; i < N_OFF; i++) begin
            if ((i % SYM_W) == 0) begin
                any_aligned  = any_aligned  | win_hit[i];
            end else begin
                any_misalign = any_misalign | win_hit[i];
            end
        end
    end

    // An aligned comma anywhere in the word wins over a misaligned one.
    assign aligned_hit  = rx.rx_valid & any_aligned;
    assign misalign_hit = rx.rx_valid & any_misalign & ~any_aligned;

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    state_t            state_q,   state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q,  bad_cnt_d;
    logic              unlock;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the edge, independent of the
    // order in which processes run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HUNT;
            wait_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        unlock     = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                if (aligned_hit) begin
                    if (LOCK_CNT <= 1) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d    = ST_VERIFY;
                        good_cnt_d = GOOD_W'(1);
                    end
                end else if (misalign_hit) begin
                    state_d = ST_SLIP;
                end
            end

            // The pulse itself is issued by the output register on entry.
            ST_SLIP: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end

            // Settle timer runs on every clock, valid data or not.
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_HUNT;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_VERIFY: begin
                if (aligned_hit) begin
                    if (good_cnt_q == GOOD_LAST) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end else if (misalign_hit) begin
                    state_d    = ST_HUNT;
                    good_cnt_d = '0;
                end
            end

            ST_LOCKED: begin
                if (aligned_hit) begin
                    bad_cnt_d = '0;
                end else if (misalign_hit) begin
                    if (bad_cnt_q == BAD_LAST) begin
                        state_d   = ST_HUNT;
                        bad_cnt_d = '0;
                        unlock    = 1'b1;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Disable overrides everything and never reports a lock loss.
        if (!enable) begin
            state_d    = ST_HUNT;
            wait_cnt_d = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            unlock     = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (from the next state, so the registered outputs line up
    // with align_state)
    // -----------------------------------------------------------------------
    logic       bitslip_d;
    logic       word_lock_d;
    logic       lock_loss_d;
    logic [7:0] slip_count_d;

    always_comb begin
        bitslip_d    = (state_d == ST_SLIP);
        word_lock_d  = (state_d == ST_LOCKED);
        lock_loss_d  = unlock;
        slip_count_d = slip_count;
        if (bitslip_d && (slip_count != 8'hFF)) begin
            slip_count_d = slip_count + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic bitslip_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitslip_q  <= 1'b0;
            word_lock  <= 1'b0;
            lock_loss  <= 1'b0;
            slip_count <= 8'd0;
        end else begin
            bitslip_q  <= bitslip_d;
            word_lock  <= word_lock_d;
            lock_loss  <= lock_loss_d;
            slip_count <= slip_count_d;
        end
    end

    assign rx.bitslip  = bitslip_q;
    assign align_state = state_q;

endmodule : pcs_serdes_word_align_ctrl

// File: tb/tb_pcs_serdes_word_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pcs_serdes_word_align_ctrl
//   Directed bench for the word-alignment controller. Words are driven on the
//   falling edge and outputs are read 1 ns after the rising edge that
//   sampled them. A falling-edge monitor counts bitslip and lock_loss pulses
//   and records the smallest spacing between bitslip pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pcs_serdes_word_align_ctrl;

    localparam int               DATA_W = 320;
    localparam logic [9:0]       COMMA  = 10'b0011111010;
    localparam logic [2:0]       S_HUNT = 3'd0, S_SLIP = 3'd1, S_WAIT = 3'd2,
                                 S_VER  = 3'd3, S_LOCK = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       word_lock;
    logic [2:0] align_state;
    logic [7:0] slip_count;
    logic       lock_loss;

    pcs_serdes_word_align_ctrl_if #(.DATA_W(DATA_W)) bus ();

    pcs_serdes_word_align_ctrl dut (
        .clk         (clk),
        .reset       (rst_n),
        .enable      (enable),
        .rx          (bus.slave),
        .word_lock   (word_lock),
        .align_state (align_state),
        .slip_count  (slip_count),
        .lock_loss   (lock_loss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Pulse monitor
    // -----------------------------------------------------------------------
    int cycle;
    int slips_seen;
    int loss_seen;
    int last_slip;
    int min_gap;
    int double_pulse;
    logic prev_slip;

    initial begin
        cycle = 0; slips_seen = 0; loss_seen = 0;
        last_slip = -1; min_gap = 1000000; double_pulse = 0; prev_slip = 1'b0;
    end

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (bus.bitslip) begin
            slips_seen++;
            if (prev_slip) double_pulse++;
            if (last_slip >= 0 && (cycle - last_slip) < min_gap) min_gap = cycle - last_slip;
            last_slip = cycle;
        end
        if (lock_loss) loss_seen++;
        prev_slip = bus.bitslip;
    end

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] word_at(input int off, input logic [9:0] pat);
        logic [DATA_W-1:0] w;
        w = '0;
        w[off +: 10] = pat;
        return w;
    endfunction

    // Drive one word on the falling edge; return 1 ns after it is sampled.
    task automatic send(input logic v, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.rx_valid = v;
        bus.sig_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic v, input logic [DATA_W-1:0] d);
        for (int i = 0; i < n; i++) send(v, d);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] w_al, w_mis, w_junk, w_rdp, w_idle;
    int start;
    int budget;

    initial begin
        total = 0; bad = 0;
        w_al   = word_at(0, COMMA);
        w_mis  = word_at(3, COMMA);
        w_junk = word_at(5, COMMA);
        w_rdp  = word_at(310, ~COMMA);
        w_idle = '0;

        rst_n = 1'b0; enable = 1'b1;
        bus.rx_valid = 1'b0; bus.sig_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",   32'(align_state), 32'(S_HUNT));
        check("rst_lock",    32'(word_lock),   0);
        check("rst_slipcnt", 32'(slip_count),  0);
        check("rst_bitslip", 32'(bus.bitslip), 0);
        check("rst_loss",    32'(lock_loss),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Aligned comma in symbol 0: lock after the fourth word.
        send(1'b1, w_al);
        check("t1_w1_state", 32'(align_state), 32'(S_VER));
        send_n(2, 1'b1, w_al);
        check("t1_w3_lock",  32'(word_lock),   0);
        send(1'b1, w_al);
        check("t1_w4_lock",  32'(word_lock),   1);
        check("t1_w4_state", 32'(align_state), 32'(S_LOCK));
        check("t1_noslip",   32'(slips_seen),  0);

        // 3a. Eight misaligned words drop the lock.
        send_n(7, 1'b1, w_mis);
        check("t3_m7_lock",  32'(word_lock),   1);
        check("t3_m7_loss",  32'(lock_loss),   0);
        send(1'b1, w_mis);
        check("t3_m8_loss",  32'(lock_loss),   1);
        check("t3_m8_lock",  32'(word_lock),   0);
        check("t3_m8_state", 32'(align_state), 32'(S_HUNT));
        send(1'b0, w_idle);
        check("t3_loss_1cy", 32'(lock_loss),   0);

        // 3b. An aligned word at position 7 restarts the bad-word count.
        send_n(4, 1'b1, w_al);
        check("t3b_relock",  32'(word_lock),   1);
        send_n(6, 1'b1, w_mis);
        send(1'b1, w_al);
        send(1'b1, w_mis);
        check("t3b_held",    32'(word_lock),   1);
        send_n(6, 1'b1, w_mis);
        check("t3b_7bad",    32'(word_lock),   1);
        send(1'b1, w_mis);
        check("t3b_8bad",    32'(lock_loss),   1);
        send(1'b0, w_idle);
        check("t3_noslip",   32'(slips_seen),  0);

        // 2. Comma at bit offset 3: one slip, 32 cycles of ignored data.
        send(1'b1, w_mis);
        check("t2_bitslip",  32'(bus.bitslip), 1);
        check("t2_state",    32'(align_state), 32'(S_SLIP));
        check("t2_slipcnt",  32'(slip_count),  1);
        send(1'b1, w_junk);
        check("t2_pulse1",   32'(bus.bitslip), 0);
        check("t2_wait",     32'(align_state), 32'(S_WAIT));
        send_n(31, 1'b1, w_junk);
        check("t2_wait_end", 32'(align_state), 32'(S_WAIT));
        send(1'b1, w_junk);
        check("t2_hunt",     32'(align_state), 32'(S_HUNT));
        send_n(4, 1'b1, w_al);
        check("t2_lock",     32'(word_lock),   1);
        check("t2_slipcnt2", 32'(slip_count),  1);
        check("t2_slips",    32'(slips_seen),  1);

        // 4. RD+ comma in symbol 31 with rx_valid gaps.
        enable = 1'b0;
        send(1'b0, w_idle);
        check("t4_dis_state", 32'(align_state), 32'(S_HUNT));
        check("t4_dis_lock",  32'(word_lock),   0);
        check("t4_dis_loss",  32'(lock_loss),   0);
        enable = 1'b1;
        send(1'b1, w_rdp);
        send(1'b0, w_idle);
        send(1'b1, w_rdp);
        send(1'b0, w_rdp);
        send(1'b0, w_idle);
        send(1'b1, w_rdp);
        check("t4_w3_state", 32'(align_state), 32'(S_VER));
        check("t4_w3_lock",  32'(word_lock),   0);
        send(1'b0, w_idle);
        send(1'b1, w_rdp);
        check("t4_w4_lock",  32'(word_lock),   1);

        // 6a. enable=0 in VERIFY clears the good-word count.
        enable = 1'b0;
        send(1'b0, w_idle);
        enable = 1'b1;
        send_n(2, 1'b1, w_al);
        check("t6_verify",   32'(align_state), 32'(S_VER));
        enable = 1'b0;
        send(1'b1, w_al);
        check("t6_dis_st",   32'(align_state), 32'(S_HUNT));
        check("t6_dis_slip", 32'(bus.bitslip), 0);
        enable = 1'b1;
        send_n(3, 1'b1, w_al);
        check("t6_restart",  32'(word_lock),   0);
        send(1'b1, w_al);
        check("t6_relock",   32'(word_lock),   1);
        enable = 1'b0;
        send_n(2, 1'b1, w_mis);
        check("t6_dis_noslip", 32'(slip_count), 1);
        check("t6_dis_noloss", 32'(lock_loss),  0);
        enable = 1'b1;
        send(1'b0, w_idle);

        // 6b. Asynchronous reset while LOCKED.
        send_n(4, 1'b1, w_al);
        check("t6b_locked",  32'(word_lock),   1);
        #2 rst_n = 1'b0;
        #1;
        check("t6b_rst_st",  32'(align_state), 32'(S_HUNT));
        check("t6b_rst_lk",  32'(word_lock),   0);
        check("t6b_rst_cnt", 32'(slip_count),  0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, w_idle);
        check("t6b_noloss",  32'(lock_loss),   0);
        check("t6b_noslip",  32'(bus.bitslip), 0);
        check("loss_total",  32'(loss_seen),   2);

        // 5. Persistent misalignment: 300 slips, counter saturates.
        start  = slips_seen;
        budget = 0;
        while ((slips_seen - start) < 300 && budget < 12000) begin
            send(1'b1, w_mis);
            budget++;
        end
        check("t5_slips",    32'(slips_seen - start), 300);
        check("t5_saturate", 32'(slip_count),         255);
        check("t5_min_gap",  32'(min_gap >= 34),      1);
        check("t5_single",   32'(double_pulse),       0);
        check("t5_noloss",   32'(loss_seen),          2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pcs_serdes_word_align_ctrl
